// File: rtl/hazard_ctrl_if.sv
// Control bundle between the pipeline datapath and hazard_ctrl.
// Hazard-detection inputs flow in; register enables, flushes, status and counter flow out.
// Pure wiring: no latency and no backpressure of its own.
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       ifid_rs;
  logic [3:0]       ifid_rt;
  logic             ifid_rs_used;
  logic             ifid_rt_used;
  logic             ifid_hlt;
  logic             idex_memread;
  logic [3:0]       idex_rd;
  logic             br_taken;
  logic             imem_rdy;
  logic             dmem_busy;
  logic             pc_en;
  logic             ifid_en;
  logic             ifid_flush;
  logic             idex_en;
  logic             idex_flush;
  logic             exmem_en;
  logic             memwb_en;
  logic             halted;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output ifid_rs, ifid_rt, ifid_rs_used, ifid_rt_used, ifid_hlt,
           idex_memread, idex_rd, br_taken, imem_rdy, dmem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, halted, stall_cycles
  );

  modport slave (
    input  ifid_rs, ifid_rt, ifid_rs_used, ifid_rt_used, ifid_hlt,
           idex_memread, idex_rd, br_taken, imem_rdy, dmem_busy,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, halted, stall_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline enable/flush control: load-use stalls, branch flushes, memory waits, HLT drain.
// Latency: enables/flushes are combinational from inputs; state and counter update at the next edge.
// Backpressure: dmem_busy freezes every stage; imem wait and load-use stall only the front end.
module hazard_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  hz
);

  localparam int DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    drain_cnt, drain_nxt;
  logic [CNT_W-1:0] stall_cnt;
  logic             lu;
  logic             pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en;

  // R0 is hardwired zero, so a load targeting it never creates a dependency.
  assign lu = hz.idex_memread && (hz.idex_rd != 4'd0) &&
              ((hz.ifid_rs_used && (hz.ifid_rs == hz.idex_rd)) ||
               (hz.ifid_rt_used && (hz.ifid_rt == hz.idex_rd)));

  always_comb begin
    state_nxt  = state;
    drain_nxt  = drain_cnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    if (!rst) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      unique case (state)
        RUN: begin
          if (hz.dmem_busy) begin
            // full freeze: branch and load-use decisions wait for memory
          end else if (hz.br_taken) begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (lu) begin
            idex_en    = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else if (hz.ifid_hlt) begin
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            state_nxt  = DRAIN;
            drain_nxt  = DW'(DRAIN_CYCLES - 1);
          end else if (!hz.imem_rdy) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end else begin
            pc_en      = 1'b1;
            ifid_en    = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
          end
        end
        DRAIN: begin
          // Taken branches here are ignored: they are older than HLT and already resolved.
          if (!hz.dmem_busy) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            if (drain_cnt == '0) begin
              state_nxt = HALTED;
            end else begin
              drain_nxt = drain_cnt - 1'b1;
            end
          end
        end
        HALTED: begin
        end
        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      drain_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
      if (!pc_en && (state != HALTED) && (stall_cnt != {CNT_W{1'b1}})) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
    end
  end

  assign hz.pc_en        = pc_en;
  assign hz.ifid_en      = ifid_en;
  assign hz.ifid_flush   = ifid_flush;
  assign hz.idex_en      = idex_en;
  assign hz.idex_flush   = idex_flush;
  assign hz.exmem_en     = exmem_en;
  assign hz.memwb_en     = memwb_en;
  assign hz.halted       = (state == HALTED);
  assign hz.stall_cycles = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: a 16-bit and a 4-bit counter instance share stimulus and are
// compared every cycle against a behavioural model of the pipeline control rules.
module tb_hazard_ctrl;
  localparam int DRAIN_CYCLES = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       r_rst;
  logic [3:0] rs, rt, rd;
  logic       rs_used, rt_used, hlt, memread, br, imem_rdy, dmem_busy;

  hazard_ctrl_if #(.CNT_W(16)) bus ();
  hazard_ctrl_if #(.CNT_W(4))  bus_s ();

  assign bus.ifid_rs        = rs;
  assign bus.ifid_rt        = rt;
  assign bus.ifid_rs_used   = rs_used;
  assign bus.ifid_rt_used   = rt_used;
  assign bus.ifid_hlt       = hlt;
  assign bus.idex_memread   = memread;
  assign bus.idex_rd        = rd;
  assign bus.br_taken       = br;
  assign bus.imem_rdy       = imem_rdy;
  assign bus.dmem_busy      = dmem_busy;
  assign bus_s.ifid_rs      = rs;
  assign bus_s.ifid_rt      = rt;
  assign bus_s.ifid_rs_used = rs_used;
  assign bus_s.ifid_rt_used = rt_used;
  assign bus_s.ifid_hlt     = hlt;
  assign bus_s.idex_memread = memread;
  assign bus_s.idex_rd      = rd;
  assign bus_s.br_taken     = br;
  assign bus_s.imem_rdy     = imem_rdy;
  assign bus_s.dmem_busy    = dmem_busy;

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(16)) dut (
    .clk (clk),
    .rst (r_rst),
    .hz  (bus)
  );

  hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(4)) dut_s (
    .clk (clk),
    .rst (r_rst),
    .hz  (bus_s)
  );

  int          n_vec = 0;
  int          n_bad = 0;
  int          mode;        // 0 running, 1 draining, 2 halted
  int          drain_left;  // drain cycles still to go
  longint      total;       // unsaturated count of stall cycles since reset
  logic [35:0] exp_v, obs_v;

  function automatic logic lu_hit();
    return memread && (rd != 4'd0) &&
           ((rs_used && (rs == rd)) || (rt_used && (rt == rd)));
  endfunction

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en}
  function automatic logic [6:0] exp_ctrl();
    if (!r_rst)       return 7'b0010100;
    if (mode == 2)    return 7'b0000000;
    if (mode == 1)    return dmem_busy ? 7'b0000000 : 7'b0111011;
    if (dmem_busy)    return 7'b0000000;
    if (br)           return 7'b1111111;
    if (lu_hit())     return 7'b0001111;
    if (hlt)          return 7'b0001011;
    if (!imem_rdy)    return 7'b0111011;
    return 7'b1101011;
  endfunction

  task automatic set_in(input logic i_rst, input logic i_memread, input logic [3:0] i_rd,
                        input logic [3:0] i_rs, input logic i_rs_used,
                        input logic [3:0] i_rt, input logic i_rt_used,
                        input logic i_br, input logic i_hlt, input logic i_imem, input logic i_busy);
    @(negedge clk);
    r_rst = i_rst; memread = i_memread; rd = i_rd; rs = i_rs; rs_used = i_rs_used;
    rt = i_rt; rt_used = i_rt_used; br = i_br; hlt = i_hlt; imem_rdy = i_imem; dmem_busy = i_busy;
  endtask

  task automatic set_quiet();
    set_in(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic set_rand();
    @(negedge clk);
    r_rst     = ($urandom_range(0, 149) != 0);
    memread   = $urandom_range(0, 1) == 1;
    rd        = 4'($urandom_range(0, 3));
    rs        = 4'($urandom_range(0, 3));
    rt        = 4'($urandom_range(0, 3));
    rs_used   = $urandom_range(0, 1) == 1;
    rt_used   = $urandom_range(0, 1) == 1;
    br        = ($urandom_range(0, 5) == 0);
    hlt       = ($urandom_range(0, 39) == 0);
    imem_rdy  = ($urandom_range(0, 3) != 0);
    dmem_busy = ($urandom_range(0, 4) == 0);
  endtask

  task automatic settle();
    logic [6:0] ec;
    #1;
    ec    = exp_ctrl();
    exp_v = {ec, (mode == 2),
             (total > 65535) ? 16'hFFFF : 16'(total),
             (total > 15) ? 4'hF : 4'(total),
             ec, (mode == 2)};
    obs_v = {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en, bus.idex_flush,
             bus.exmem_en, bus.memwb_en, bus.halted, bus.stall_cycles, bus_s.stall_cycles,
             bus_s.pc_en, bus_s.ifid_en, bus_s.ifid_flush, bus_s.idex_en, bus_s.idex_flush,
             bus_s.exmem_en, bus_s.memwb_en, bus_s.halted};
  endtask

  task automatic tick();
    logic [6:0] ec;
    ec = exp_ctrl();
    @(posedge clk);
    if (!r_rst) begin
      mode = 0; drain_left = 0; total = 0;
    end else begin
      if (!ec[6] && mode != 2) total++;
      if (mode == 0 && !dmem_busy && !br && !lu_hit() && hlt) begin
        mode = 1; drain_left = DRAIN_CYCLES;
      end else if (mode == 1 && !dmem_busy) begin
        drain_left--;
        if (drain_left == 0) mode = 2;
      end
    end
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      set_rand();
      r_rst = 1'b0;
      settle();
      n_vec++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL reset c%0d: got %h want %h", i, obs_v, exp_v); end
      tick();
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_in(1'b1, 1'b1, 4'd3, 4'd3, 1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    settle();
    n_vec++;
    if (obs_v !== exp_v) begin n_bad++; $display("FAIL load_use stall: got %h want %h", obs_v, exp_v); end
    tick();
    set_quiet();
    settle();
    n_vec++;
    if (obs_v !== exp_v) begin n_bad++; $display("FAIL load_use after: got %h want %h", obs_v, exp_v); end
    n_vec++;
    if (bus.stall_cycles !== 16'd1) begin n_bad++; $display("FAIL load_use count: got %0d want 1", bus.stall_cycles); end
    tick();
  endtask

  task automatic test_r0_and_rt();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      // i: 0 rd=R0 via rs, 1 rd=R0 via rt, 2 rt hit, 3 rt match but unused
      set_in(1'b1, 1'b1, (i < 2) ? 4'd0 : 4'd7, 4'd0, (i == 0), (i < 2) ? 4'd0 : 4'd7,
             (i != 0 && i != 3), 1'b0, 1'b0, 1'b1, 1'b0);
      settle();
      n_vec++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL r0_rt c%0d: got %h want %h", i, obs_v, exp_v); end
      tick();
    end
  endtask

  task automatic test_branch_lu();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      // 0 branch+lu, 1 branch+hlt, 2 branch+imem wait
      set_in(1'b1, (i == 0), 4'd2, 4'd2, 1'b1, 4'd0, 1'b0, 1'b1, (i == 1), (i != 2), 1'b0);
      settle();
      n_vec++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL branch c%0d: got %h want %h", i, obs_v, exp_v); end
      tick();
    end
    set_quiet();
    settle();
    n_vec++;
    if (obs_v !== exp_v) begin n_bad++; $display("FAIL branch after: got %h want %h", obs_v, exp_v); end
    tick();
  endtask

  task automatic test_dmem_freeze();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      set_in(1'b1, (i < 5), 4'd4, 4'd4, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1, (i < 4));
      settle();
      n_vec++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL dmem c%0d: got %h want %h", i, obs_v, exp_v); end
      tick();
    end
    set_quiet();
    #1;
    n_vec++;
    if (bus.stall_cycles !== 16'd5) begin n_bad++; $display("FAIL dmem count: got %0d want 5", bus.stall_cycles); end
    tick();
  endtask

  task automatic test_halt();
    int halt_at;
    halt_at = -1;
    do_reset();
    set_in(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    settle();
    n_vec++;
    if (obs_v !== exp_v) begin n_bad++; $display("FAIL halt issue: got %h want %h", obs_v, exp_v); end
    tick();
    for (int k = 1; k <= 7; k++) begin
      set_quiet();
      br = (k == 2);
      settle();
      n_vec++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL halt drain k%0d: got %h want %h", k, obs_v, exp_v); end
      if (bus.halted === 1'b1 && halt_at < 0) halt_at = k;
      tick();
    end
    n_vec++;
    if (halt_at != DRAIN_CYCLES + 1) begin n_bad++; $display("FAIL halt edges: got %0d want %0d", halt_at, DRAIN_CYCLES + 1); end
    do_reset();
    set_quiet();
    settle();
    n_vec++;
    if (obs_v !== exp_v) begin n_bad++; $display("FAIL halt reset: got %h want %h", obs_v, exp_v); end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 20; i++) begin
      set_in(1'b1, 1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      settle();
      n_vec++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL sat c%0d: got %h want %h", i, obs_v, exp_v); end
      tick();
    end
    set_quiet();
    #1;
    n_vec++;
    if (bus_s.stall_cycles !== 4'hF) begin n_bad++; $display("FAIL sat hold: got %h want f", bus_s.stall_cycles); end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      set_rand();
      settle();
      n_vec++;
      if (obs_v !== exp_v) begin n_bad++; $display("FAIL random c%0d: got %h want %h", i, obs_v, exp_v); end
      tick();
    end
  endtask

  initial begin
    mode = 0; drain_left = 0; total = 0;
    r_rst = 1'b0; memread = 1'b0; rd = 4'd0; rs = 4'd0; rt = 4'd0; rs_used = 1'b0;
    rt_used = 1'b0; br = 1'b0; hlt = 1'b0; imem_rdy = 1'b1; dmem_busy = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_load_use();
    test_r0_and_rt();
    test_branch_lu();
    test_dmem_freeze();
    test_halt();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline control unit for the 5-stage 16-bit core.
- Drives enable/flush of PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Resolves load-use stalls, taken-branch flushes, instruction/data memory wait states and HLT drain.
- Keeps a saturating stall-cycle counter for performance debug.

Parameters:
DRAIN_CYCLES, 3, cycles after HLT leaves ID before halted asserts (lets older instructions retire)
CNT_W, 16, width of stall_cycles counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous reset, active-low
ifid_rs  input  4  source register rs of instruction in ID
ifid_rt  input  4  source register rt of instruction in ID
ifid_rs_used  input  1  ID instruction reads rs
ifid_rt_used  input  1  ID instruction reads rt
ifid_hlt  input  1  ID instruction is HLT (opcode 4'hF)
idex_memread  input  1  EX instruction is a load
idex_rd  input  4  destination register of EX instruction
br_taken  input  1  branch/jump resolved taken in EX this cycle
imem_rdy  input  1  instruction memory has valid data this cycle
dmem_busy  input  1  data memory access in MEM not complete
pc_en  output  1  PC register write enable
ifid_en  output  1  IF/ID write enable
ifid_flush  output  1  IF/ID loads NOP
idex_en  output  1  ID/EX write enable
idex_flush  output  1  ID/EX loads bubble
exmem_en  output  1  EX/MEM write enable
memwb_en  output  1  MEM/WB write enable
halted  output  1  core halted, sticky until reset
stall_cycles  output  CNT_W  saturating count of cycles with pc_en=0 and not halted

Behaviour:
- One clock (clk); reset is synchronous and active-low (rst). Sampled rst=0 at an edge: state<=RUN, drain_cnt<=0, stall_cycles<=0, halted<=0.
- While rst=0 (combinational): all *_en=0, ifid_flush=idex_flush=1.
- States: RUN, DRAIN, HALTED. halted=1 only in HALTED.
- Hazard terms (combinational):
  - lu = idex_memread & idex_rd!=0 & ((ifid_rs_used & ifid_rs==idex_rd) | (ifid_rt_used & ifid_rt==idex_rd)). R0 never creates a hazard.
- Output priority in RUN, highest first:
  1. dmem_busy: all enables 0, no flush. Full freeze; the branch/lu evaluation is deferred until dmem_busy drops.
  2. br_taken: pc_en=1 (target loads), ifid_en=1 with ifid_flush=1, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1. Cancels lu, imem wait and any pending HLT in ID.
  3. lu: pc_en=0, ifid_en=0, idex_en=1 with idex_flush=1, exmem_en=memwb_en=1. Exactly one bubble per load-use pair.
  4. ifid_hlt: pc_en=0, ifid_en=0 with ifid_flush=0; HLT advances (idex_en=1); next state DRAIN with drain_cnt<=DRAIN_CYCLES-1.
  5. !imem_rdy: pc_en=0, ifid_en=1 with ifid_flush=1 (bubble into ID); downstream enables 1.
  6. Otherwise all enables 1, no flush.
- DRAIN:
  - pc_en=0, ifid_en=1 with ifid_flush=1; downstream enables 1, except all 0 while dmem_busy (drain_cnt holds).
  - br_taken is ignored: any taken branch is older than HLT and was resolved before HLT left ID.
  - drain_cnt decrements each non-frozen cycle; at 0 -> HALTED.
- HALTED: all enables 0, flushes 0, halted=1; only reset exits.
- Latency: stall/flush outputs are combinational, same cycle as inputs; state changes at next edge.
- stall_cycles increments when pc_en=0 & state!=HALTED & rst=1; saturates at all-ones (no wrap).
- Simultaneous events:
  - br_taken+lu: flush wins, no bubble counted beyond the flush.
  - br_taken+ifid_hlt: HLT squashed, stay RUN.
  - lu+ifid_hlt: lu wins; HLT handled the next cycle.
  - Reset mid-DRAIN or in HALTED: returns to RUN next edge.

Test Plan:
- LW R3 in EX (idex_memread=1, idex_rd=3) with ID rs=3 used -> one cycle pc_en=0, ifid_en=0, idex_flush=1; stall_cycles 0->1.
- Same with idex_rd=0 -> no stall, all enables 1, stall_cycles unchanged.
- br_taken=1 together with lu=1 -> pc_en=1, ifid_flush=1, idex_flush=1, no stall; stall_cycles unchanged.
- dmem_busy=1 for 4 cycles during lu -> all enables 0 for 4 cycles, then one lu bubble; stall_cycles +5.
- ifid_hlt=1, DRAIN_CYCLES=3, no other events -> halted rises exactly 4 edges after the HLT cycle; pc_en stays 0; rst=0 then 1 -> halted=0, state RUN, stall_cycles=0.
- Force counter to 16'hFFFE, hold imem_rdy=0 for 3 cycles -> stall_cycles ends at 16'hFFFF, no wrap.
